order_book_update: RTL and testbench

- Parametrised successor to the single-mode add-order engine.
- Accepts ADD, CANCEL and REDUCE order requests over a valid/ready handshake and performs a read-check-write against the order-book entry memory.
- Returns a per-request status on a response handshake.
- Sits between the order-message decoder and the order-book entry RAM; the entry slot is selected directly by order_id[ADDR_W-1:0].

---
 rtl/order_book_update_pkg.sv | 40 ++++
 rtl/order_book_update_if.sv | 56 +++++
 rtl/order_book_update_sat_counter.sv | 22 ++
 rtl/order_book_update.sv | 244 ++++++++++++++++++++++++
 tb/tb_order_book_update.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/order_book_update_pkg.sv
// Shared types for the order-book update engine: opcodes, response status codes,
// the packed entry layout and the memory request bundle.
package order_book_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int ID_W_DEF    = 32;
  localparam int QTY_W_DEF   = 32;
  localparam int PRICE_W_DEF = 64;
  localparam int CNT_W_DEF   = 16;
  localparam int ENTRY_W     = 1 + ID_W_DEF + QTY_W_DEF + PRICE_W_DEF;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_CANCEL = 2'd1,
    OP_REDUCE = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_COLLISION = 3'd1,
    ST_NOT_FOUND = 3'd2,
    ST_UNDERFLOW = 3'd3,
    ST_BAD_OP    = 3'd4
  } status_e;

  typedef struct packed {
    logic                   valid;
    logic [ID_W_DEF-1:0]    order_id;
    logic [QTY_W_DEF-1:0]   quantity;
    logic [PRICE_W_DEF-1:0] price;
  } entry_t;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_W_DEF-1:0] addr;
    logic [ENTRY_W-1:0]    wr_data;
  } mem_req_t;

endpackage

// File: rtl/order_book_update_if.sv
// Request, entry-memory and response channels of the order-book update engine.
// The slave modport is the engine side, master is the decoder/RAM/consumer side.
interface order_book_update_if #(
  parameter int ADDR_W  = 10,
  parameter int ID_W    = 32,
  parameter int QTY_W   = 32,
  parameter int PRICE_W = 64,
  parameter int CNT_W   = 16
);
  localparam int ENTRY_W = 1 + ID_W + QTY_W + PRICE_W;

  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [ID_W-1:0]    req_order_id;
  logic [QTY_W-1:0]   req_quantity;
  logic [PRICE_W-1:0] req_price;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_wr;
  logic [ADDR_W-1:0]  mem_addr;
  logic [ENTRY_W-1:0] mem_wr_data;
  logic               mem_rd_valid;
  logic [ENTRY_W-1:0] mem_rd_data;

  logic               resp_valid;
  logic               resp_ready;
  logic [2:0]         resp_status;
  logic [ID_W-1:0]    resp_order_id;
  logic [QTY_W-1:0]   resp_quantity;

  logic [CNT_W-1:0]   cnt_ok;
  logic [CNT_W-1:0]   cnt_err;

  modport slave (
    input  req_valid, req_op, req_order_id, req_quantity, req_price,
    output req_ready,
    output mem_req_valid, mem_wr, mem_addr, mem_wr_data,
    input  mem_req_ready, mem_rd_valid, mem_rd_data,
    output resp_valid, resp_status, resp_order_id, resp_quantity,
    input  resp_ready,
    output cnt_ok, cnt_err
  );

  modport master (
    output req_valid, req_op, req_order_id, req_quantity, req_price,
    input  req_ready,
    input  mem_req_valid, mem_wr, mem_addr, mem_wr_data,
    output mem_req_ready, mem_rd_valid, mem_rd_data,
    input  resp_valid, resp_status, resp_order_id, resp_quantity,
    output resp_ready,
    input  cnt_ok, cnt_err
  );

endinterface

// File: rtl/order_book_update_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up on inc until the all-ones ceiling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/order_book_update.sv
// Order-book update engine: ADD / CANCEL / REDUCE as a read-check-write on the
// entry RAM slot order_id[ADDR_W-1:0], one request in flight, status per request.
module order_book_update
  import order_book_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int ID_W    = 32,
  parameter int QTY_W   = 32,
  parameter int PRICE_W = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  order_book_update_if.slave   bus
);

  localparam int EW = 1 + ID_W + QTY_W + PRICE_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_EVAL = 3'd3,
    S_WR   = 3'd4,
    S_RESP = 3'd5
  } state_e;

  state_e             state_r;
  op_e                op_r;
  logic [ID_W-1:0]    id_r;
  logic [QTY_W-1:0]   qty_r;
  logic [PRICE_W-1:0] price_r;
  logic [EW-1:0]      entry_r;

  logic               req_ready_r;
  logic               mem_req_valid_r;
  logic               mem_wr_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [EW-1:0]      mem_wr_data_r;
  logic               resp_valid_r;
  status_e            resp_status_r;
  logic [ID_W-1:0]    resp_order_id_r;
  logic [QTY_W-1:0]   resp_quantity_r;

  logic               e_valid_s;
  logic [ID_W-1:0]    e_id_s;
  logic [QTY_W-1:0]   e_qty_s;
  logic [PRICE_W-1:0] e_price_s;
  logic               hit_s;
  logic               wr_need_s;
  logic [EW-1:0]      new_entry_s;
  status_e            eval_status_s;
  logic [QTY_W-1:0]   eval_qty_s;
  logic               inc_ok_s;
  logic               inc_err_s;
  logic [CNT_W-1:0]   cnt_ok_s;
  logic [CNT_W-1:0]   cnt_err_s;

  assign e_valid_s = entry_r[EW-1];
  assign e_id_s    = entry_r[EW-2 -: ID_W];
  assign e_qty_s   = entry_r[QTY_W+PRICE_W-1 -: QTY_W];
  assign e_price_s = entry_r[PRICE_W-1:0];
  assign hit_s     = e_valid_s && (e_id_s == id_r);

  // decide the outcome of the captured request against the entry read back
  always_comb begin
    wr_need_s     = 1'b0;
    new_entry_s   = {EW{1'b0}};
    eval_status_s = ST_BAD_OP;
    eval_qty_s    = {QTY_W{1'b0}};
    case (op_r)
      OP_ADD: begin
        if (!e_valid_s) begin
          wr_need_s     = 1'b1;
          new_entry_s   = {1'b1, id_r, qty_r, price_r};
          eval_status_s = ST_OK;
          eval_qty_s    = qty_r;
        end else begin
          eval_status_s = ST_COLLISION;
        end
      end
      OP_CANCEL: begin
        if (hit_s) begin
          wr_need_s     = 1'b1;
          eval_status_s = ST_OK;
        end else begin
          eval_status_s = ST_NOT_FOUND;
        end
      end
      OP_REDUCE: begin
        if (!hit_s) begin
          eval_status_s = ST_NOT_FOUND;
        end else if (qty_r > e_qty_s) begin
          eval_status_s = ST_UNDERFLOW;
        end else if (qty_r == e_qty_s) begin
          // fully drained: the slot is released rather than kept at zero quantity
          wr_need_s     = 1'b1;
          eval_status_s = ST_OK;
        end else begin
          wr_need_s     = 1'b1;
          new_entry_s   = {1'b1, id_r, e_qty_s - qty_r, e_price_s};
          eval_status_s = ST_OK;
          eval_qty_s    = e_qty_s - qty_r;
        end
      end
      default: begin
        eval_status_s = ST_BAD_OP;
      end
    endcase
  end

  // request FSM; every interface output is a register updated on state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= S_IDLE;
      op_r            <= OP_ADD;
      id_r            <= {ID_W{1'b0}};
      qty_r           <= {QTY_W{1'b0}};
      price_r         <= {PRICE_W{1'b0}};
      entry_r         <= {EW{1'b0}};
      req_ready_r     <= 1'b1;
      mem_req_valid_r <= 1'b0;
      mem_wr_r        <= 1'b0;
      mem_addr_r      <= {ADDR_W{1'b0}};
      mem_wr_data_r   <= {EW{1'b0}};
      resp_valid_r    <= 1'b0;
      resp_status_r   <= ST_OK;
      resp_order_id_r <= {ID_W{1'b0}};
      resp_quantity_r <= {QTY_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.req_valid && req_ready_r) begin
            op_r        <= op_e'(bus.req_op);
            id_r        <= bus.req_order_id;
            qty_r       <= bus.req_quantity;
            price_r     <= bus.req_price;
            req_ready_r <= 1'b0;
            if (op_e'(bus.req_op) == OP_RSVD) begin
              resp_valid_r    <= 1'b1;
              resp_status_r   <= ST_BAD_OP;
              resp_order_id_r <= bus.req_order_id;
              resp_quantity_r <= {QTY_W{1'b0}};
              state_r         <= S_RESP;
            end else begin
              mem_req_valid_r <= 1'b1;
              mem_wr_r        <= 1'b0;
              mem_addr_r      <= bus.req_order_id[ADDR_W-1:0];
              state_r         <= S_RD;
            end
          end
        end
        S_RD: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            state_r         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rd_valid) begin
            entry_r <= bus.mem_rd_data;
            state_r <= S_EVAL;
          end
        end
        S_EVAL: begin
          resp_status_r   <= eval_status_s;
          resp_order_id_r <= id_r;
          resp_quantity_r <= eval_qty_s;
          if (wr_need_s) begin
            mem_req_valid_r <= 1'b1;
            mem_wr_r        <= 1'b1;
            mem_wr_data_r   <= new_entry_s;
            state_r         <= S_WR;
          end else begin
            resp_valid_r <= 1'b1;
            state_r      <= S_RESP;
          end
        end
        S_WR: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            mem_wr_r        <= 1'b0;
            resp_valid_r    <= 1'b1;
            state_r         <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= S_IDLE;
          end
        end
        default: begin
          state_r         <= S_IDLE;
          req_ready_r     <= 1'b1;
          mem_req_valid_r <= 1'b0;
          mem_wr_r        <= 1'b0;
          resp_valid_r    <= 1'b0;
        end
      endcase
    end
  end

  // statistics pulses on the response handshake
  always_comb begin
    inc_ok_s  = 1'b0;
    inc_err_s = 1'b0;
    if ((state_r == S_RESP) && bus.resp_ready) begin
      inc_ok_s  = (resp_status_r == ST_OK);
      inc_err_s = (resp_status_r != ST_OK);
    end else begin
      inc_ok_s  = 1'b0;
      inc_err_s = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_ok (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_ok_s),
    .count (cnt_ok_s)
  );

  sat_counter #(.W(CNT_W)) u_cnt_err (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_err_s),
    .count (cnt_err_s)
  );

  assign bus.req_ready     = req_ready_r;
  assign bus.mem_req_valid = mem_req_valid_r;
  assign bus.mem_wr        = mem_wr_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_wr_data   = mem_wr_data_r;
  assign bus.resp_valid    = resp_valid_r;
  assign bus.resp_status   = resp_status_r;
  assign bus.resp_order_id = resp_order_id_r;
  assign bus.resp_quantity = resp_quantity_r;
  assign bus.cnt_ok        = cnt_ok_s;
  assign bus.cnt_err       = cnt_err_s;

endmodule

// File: tb/tb_order_book_update.sv
// Bench for order_book_update: behavioural entry RAM with stall/latency control,
// directed plan steps, randomized traffic and a mid-operation reset.
module tb_order_book_update;
  import order_book_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  order_book_update_if bus ();

  order_book_update dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  entry_t ram [0:1023];
  int n_vec  = 0;
  int n_fail = 0;
  int exp_ok = 0;
  int exp_err = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: outcome of one request against the current slot contents
  function automatic void model(input logic [1:0] op, input logic [31:0] id, input logic [31:0] qty,
                                input logic [63:0] price, input entry_t cur,
                                output logic [2:0] st, output logic [31:0] rq,
                                output logic wr, output entry_t nxt);
    bit hit;
    hit = cur.valid && (cur.order_id == id);
    st = 3'd4; rq = 32'd0; wr = 1'b0; nxt = '0;
    if (op == 2'd0) begin
      if (cur.valid) st = 3'd1;
      else begin st = 3'd0; rq = qty; wr = 1'b1; nxt = {1'b1, id, qty, price}; end
    end else if (op == 2'd1) begin
      if (!hit) st = 3'd2;
      else begin st = 3'd0; wr = 1'b1; end
    end else if (op == 2'd2) begin
      if (!hit) st = 3'd2;
      else if (qty > cur.quantity) st = 3'd3;
      else begin
        st = 3'd0; wr = 1'b1; rq = cur.quantity - qty;
        if (rq != 32'd0) nxt = {1'b1, id, rq, cur.price};
      end
    end
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"},  bus.req_ready, 1'b1);
    check({tag, "_mem_valid"},  bus.mem_req_valid, 1'b0);
    check({tag, "_mem_wr"},     bus.mem_wr, 1'b0);
    check({tag, "_mem_addr"},   bus.mem_addr, 10'd0);
    check({tag, "_mem_wdata"},  bus.mem_wr_data, 129'd0);
    check({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
    check({tag, "_resp_st"},    bus.resp_status, 3'd0);
    check({tag, "_resp_id"},    bus.resp_order_id, 32'd0);
    check({tag, "_resp_qty"},   bus.resp_quantity, 32'd0);
    check({tag, "_cnt_ok"},     bus.cnt_ok, 16'd0);
    check({tag, "_cnt_err"},    bus.cnt_err, 16'd0);
  endtask

  // one full request: drive, serve the RAM side, consume the response, compare
  task automatic do_op(input logic [1:0] op, input logic [31:0] id, input logic [31:0] qty,
                       input logic [63:0] price, input int stall, input int rd_lat,
                       input int hold, input bit junk);
    entry_t cur, nxt, wr_data;
    logic [2:0] st, r_st;
    logic [31:0] rq, r_id, r_qty;
    logic wr, req_wr0;
    logic [9:0] rd_addr, wr_addr, req_addr0;
    logic [159:0] jv;
    int n_wr, n_rd, cyc, lat, stall_cnt, hold_cnt, rd_cnt, exp_lat;
    bit rd_pend, rd_issued, in_req, resp_seen, done;
    n_wr = 0; n_rd = 0; lat = -1; stall_cnt = 0; hold_cnt = 0; rd_cnt = 0;
    rd_pend = 0; rd_issued = 0; in_req = 0; resp_seen = 0; done = 0;
    rd_addr = '0; wr_addr = '0; req_addr0 = '0; req_wr0 = 1'b0; wr_data = '0;
    r_st = '0; r_id = '0; r_qty = '0;
    cur = ram[id[9:0]];
    model(op, id, qty, price, cur, st, rq, wr, nxt);

    for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_order_id = id;
    bus.req_quantity = qty; bus.req_price = price;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_op = 2'($urandom); bus.req_order_id = $urandom;
    bus.req_quantity = $urandom; bus.req_price = {$urandom, $urandom};

    cyc = 1;
    while (!done && cyc < 300) begin
      bus.mem_rd_valid = 1'b0;
      if (rd_pend) begin
        rd_cnt++;
        if (rd_cnt >= rd_lat) begin
          bus.mem_rd_valid = 1'b1; bus.mem_rd_data = ram[rd_addr]; rd_pend = 0;
        end
      end else if (junk && !rd_issued) begin
        jv = {$urandom, $urandom, $urandom, $urandom, $urandom};
        bus.mem_rd_valid = 1'b1; bus.mem_rd_data = jv[128:0];
      end
      if (bus.mem_req_valid) begin
        if (!in_req) begin
          in_req = 1; req_addr0 = bus.mem_addr; req_wr0 = bus.mem_wr;
        end else begin
          check("mem_addr_stable", bus.mem_addr, req_addr0);
          check("mem_wr_stable", bus.mem_wr, req_wr0);
        end
        if (stall_cnt < stall) begin
          bus.mem_req_ready = 1'b0; stall_cnt++;
        end else begin
          bus.mem_req_ready = 1'b1; stall_cnt = 0; in_req = 0;
          if (bus.mem_wr) begin
            n_wr++; wr_addr = bus.mem_addr; wr_data = entry_t'(bus.mem_wr_data);
            ram[bus.mem_addr] = entry_t'(bus.mem_wr_data);
          end else begin
            n_rd++; rd_pend = 1; rd_cnt = 0; rd_addr = bus.mem_addr; rd_issued = 1;
          end
        end
      end else begin
        bus.mem_req_ready = 1'b0;
      end
      check("req_ready_busy", bus.req_ready, 1'b0);
      if (bus.resp_valid) begin
        if (!resp_seen) begin
          resp_seen = 1; lat = cyc;
          r_st = bus.resp_status; r_id = bus.resp_order_id; r_qty = bus.resp_quantity;
        end else begin
          check("resp_st_stable", bus.resp_status, r_st);
          check("resp_id_stable", bus.resp_order_id, r_id);
          check("resp_qty_stable", bus.resp_quantity, r_qty);
        end
        if (hold_cnt < hold) begin
          bus.resp_ready = 1'b0; hold_cnt++;
        end else begin
          bus.resp_ready = 1'b1; done = 1;
        end
      end
      if (!done) begin
        @(negedge clk); cyc++;
      end
    end
    check("resp_timeout", done, 1'b1);
    @(negedge clk);
    bus.resp_ready = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_rd_valid = 1'b0;
    check("req_ready_after", bus.req_ready, 1'b1);
    check("resp_valid_after", bus.resp_valid, 1'b0);

    check("resp_status", r_st, st);
    check("resp_order_id", r_id, id);
    check("resp_quantity", r_qty, rq);
    check("write_count", n_wr, wr ? 1 : 0);
    check("read_count", n_rd, (op == 2'd3) ? 0 : 1);
    if (wr) begin
      check("write_addr", wr_addr, id[9:0]);
      check("write_data", wr_data, nxt);
    end
    if (stall == 0 && rd_lat == 1) begin
      exp_lat = (op == 2'd3) ? 1 : (wr ? 5 : 4);
      check("latency", lat, exp_lat);
    end
    if (st == 3'd0) exp_ok++; else exp_err++;
    check("cnt_ok", bus.cnt_ok, exp_ok);
    check("cnt_err", bus.cnt_err, exp_err);
  endtask

  initial begin
    int r;
    logic [1:0] op;
    logic [31:0] id, qty;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_order_id = 32'd0;
    bus.req_quantity = 32'd0; bus.req_price = 64'd0;
    bus.mem_req_ready = 1'b0; bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // directed plan
    do_op(2'd0, 32'h5,   32'd100, 64'h3E8, 0, 1, 0, 0);
    do_op(2'd0, 32'h405, 32'd7,   64'h99,  0, 1, 0, 0);
    do_op(2'd1, 32'h405, 32'd0,   64'h0,   0, 1, 0, 0);
    do_op(2'd2, 32'h5,   32'd30,  64'h0,   0, 1, 0, 0);
    check("slot5_qty_70", ram[5].quantity, 32'd70);
    do_op(2'd2, 32'h5,   32'd71,  64'h0,   0, 1, 0, 0);
    do_op(2'd2, 32'h5,   32'd70,  64'h0,   0, 1, 0, 0);
    check("slot5_freed", ram[5], 129'd0);
    do_op(2'd3, 32'h77,  32'd5,   64'h1,   0, 1, 5, 0);
    do_op(2'd0, 32'h12,  32'd44,  64'hABCD, 3, 4, 1, 1);
    do_op(2'd1, 32'h12,  32'd0,   64'h0,   3, 4, 0, 1);

    // randomized traffic over a few slots with aliasing ids
    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      id = {20'd0, 2'($urandom_range(0, 3)), 7'd0, 3'($urandom_range(0, 7))};
      qty = (op == 2'd2) ? 32'($urandom_range(0, 120)) : 32'($urandom_range(0, 200));
      do_op(op, id, qty, {$urandom, $urandom}, $urandom_range(0, 2),
            $urandom_range(1, 3), $urandom_range(0, 2), 1'($urandom));
    end

    // reset while waiting for read data
    for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_order_id = 32'h9;
    bus.req_quantity = 32'd11; bus.req_price = 64'h22;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_rd_valid", bus.mem_req_valid, 1'b1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("rst_in_wait", bus.mem_req_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    exp_ok = 0; exp_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.mem_rd_valid = (i == 0);
      bus.mem_rd_data = ram[9];
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      check("no_mem_after_rst", bus.mem_req_valid, 1'b0);
    end
    bus.mem_rd_valid = 1'b0; bus.mem_req_ready = 1'b0;
    check("slot9_untouched", ram[9], 129'd0);
    do_op(2'd0, 32'h9, 32'd55, 64'h1234, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
